// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULTU/DIVU sequencer with HI/LO registers and pipeline stall
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rdReq,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = ($clog2(WIDTH) > 5) ? $clog2(WIDTH) : 5;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_ext;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_step;
    logic               accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    // acc_q holds {partial product, multiplier} during MUL and {remainder, quotient} during DIV.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        rem_ext  = acc_q[2*WIDTH-1:WIDTH-1];
        trial    = rem_ext - {1'b0, opnd_q};
        div_step = trial[WIDTH] ? {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
        accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    hi_d    = mul_step[2*WIDTH-1:WIDTH];
                    lo_d    = mul_step[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                // A zero divisor spends one non-busy cycle here and completes with the fixed result.
                if (opnd_q == '0) begin
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d = div_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        hi_d    = div_step[2*WIDTH-1:WIDTH];
                        lo_d    = div_step[WIDTH-1:0];
                        dbz_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        if (accept) begin
            case (op)
                OP_MULTU: begin
                    acc_d   = {{WIDTH{1'b0}}, b};
                    opnd_d  = a;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
                OP_DIVU: begin
                    acc_d   = {{WIDTH{1'b0}}, a};
                    opnd_d  = b;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
                OP_MTHI: begin
                    hi_d    = a;
                    state_d = S_IDLE;
                end
                OP_MTLO: begin
                    lo_d    = a;
                    state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == S_MUL) || (state_q == S_DIV && opnd_q != '0);
        done      = (state_q == S_DONE);
        divByZero = (state_q == S_DONE) && dbz_q;
        stall     = busy && (start || rdReq);
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rdReq;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rdReq(rdReq),
        .busy(busy), .done(done), .divByZero(divByZero), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drives one request for a cycle and records what the model says it must produce.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t        e;
        logic [31:0] prod;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        case (o)
            2'd0: begin
                prod  = 32'(av) * 32'(bv);
                e.hi  = prod[31:16];
                e.lo  = prod[15:0];
                e.dbz = 1'b0;
                e.due = cyc + 1 + W;
                sb.push_back(e);
            end
            2'd1: begin
                if (bv == 0) begin
                    e.hi  = av;
                    e.lo  = '1;
                    e.dbz = 1'b1;
                    e.due = cyc + 2;
                end else begin
                    e.hi  = av % bv;
                    e.lo  = av / bv;
                    e.dbz = 1'b0;
                    e.due = cyc + 1 + W;
                end
                sb.push_back(e);
            end
            2'd2: e.hi = av;
            default: e.lo = av;
        endcase
        if (o == 2'd2) mdl_hi = av;
        else if (o == 2'd3) mdl_lo = av;
        else begin
            mdl_hi = e.hi;
            mdl_lo = e.lo;
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || busy || done) && t < 200) begin
            step();
            t++;
        end
        chk("wait_idle_timeout", 32'(t < 200), 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result_hi", 32'(hi), 32'(e.hi));
                chk("result_lo", 32'(lo), 32'(e.lo));
                chk("result_dbz", 32'(divByZero), 32'(e.dbz));
                chk("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int dc;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset with a competing MTHI request: reset must win.
        rst = 1'b1; start = 1'b1; op = 2'd2; a = 16'hFFFF; b = '0; rdReq = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dbz", 32'(divByZero), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_hi", 32'(hi), 0);
        chk("rst_lo", 32'(lo), 0);
        start = 1'b0; rst = 1'b0;
        step();

        // MULTU 300*200 with busy-length check
        issue(2'd0, 16'd300, 16'd200);
        bc = 0;
        repeat (W + 3) begin
            if (busy) bc++;
            step();
        end
        chk("mul_busy_cycles", 32'(bc), 32'(W));
        chk("mul_hi_held", 32'(hi), 32'h0000);
        chk("mul_lo_held", 32'(lo), 32'hEA60);

        // Worst-case multiply, then DIVU issued in the DONE cycle
        issue(2'd0, 16'hFFFF, 16'hFFFF);
        repeat (W) step();
        chk("b2b_done_cycle", 32'(done), 1);
        issue(2'd1, 16'd100, 16'd7);
        wait_idle();
        chk("b2b_hi", 32'(hi), 32'd2);
        chk("b2b_lo", 32'(lo), 32'd14);

        // DIVU by zero: never busy
        issue(2'd1, 16'h1234, 16'h0000);
        bc = 0;
        repeat (3) begin
            if (busy) bc++;
            step();
        end
        chk("div0_busy", 32'(bc), 0);
        wait_idle();

        // Stall behaviour during MULTU; start at cycle 9 is ignored
        issue(2'd0, 16'd1234, 16'd567);
        for (int k = 1; k <= W; k++) begin
            rdReq = (k == 5);
            start = (k == 9);
            if (k == 9) begin
                op = 2'd0;
                a  = 16'($urandom);
                b  = 16'($urandom);
            end
            #1;
            chk($sformatf("stall_c%0d", k), 32'(stall), 32'(k == 5 || k == 9));
            step();
        end
        start = 1'b0;
        rdReq = 1'b1;
        #1;
        chk("stall_in_done", 32'(stall), 0);
        chk("done_after_stall", 32'(done), 1);
        step();
        rdReq = 1'b0;
        wait_idle();

        // Reset in the middle of a multiply
        issue(2'd0, 16'd300, 16'd200);
        repeat (6) step();
        rst = 1'b1;
        sb.delete();
        mdl_hi = '0;
        mdl_lo = '0;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_hi", 32'(hi), 0);
        chk("midrst_lo", 32'(lo), 0);
        dc = 0;
        repeat (W + 4) begin
            if (done) dc++;
            step();
        end
        chk("midrst_no_done", 32'(dc), 0);

        // MTHI / MTLO
        issue(2'd2, 16'hBEEF, 16'h0000);
        chk("mthi_hi", 32'(hi), 32'hBEEF);
        chk("mthi_busy", 32'(busy), 0);
        issue(2'd3, 16'h1357, 16'h0000);
        chk("mtlo_lo", 32'(lo), 32'h1357);
        chk("mtlo_hi", 32'(hi), 32'hBEEF);
        chk("mtlo_stall", 32'(stall), 0);
        chk("mtlo_done", 32'(done), 0);

        // Randomized ops, often back-to-back in the DONE cycle
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            issue(ro, ra, rb);
            if (ro >= 2'd2) begin
                chk("rnd_mt_hi", 32'(hi), 32'(mdl_hi));
                chk("rnd_mt_lo", 32'(lo), 32'(mdl_lo));
                chk("rnd_mt_busy", 32'(busy), 0);
            end else begin
                repeat ((ro == 2'd1 && rb == 0) ? 1 : W) step();
                if ($urandom_range(0, 1) == 1) step();
            end
        end
        wait_idle();
        chk("final_hi", 32'(hi), 32'(mdl_hi));
        chk("final_lo", 32'(lo), 32'(mdl_lo));
        chk("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer sitting beside the EX-stage ALU of the pipelined MIPS core. It accepts MULTU/DIVU/MTHI/MTLO requests decoded in EX, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, and holds the results in the HI/LO registers. It drives the pipeline stall request while an operation is in flight and an instruction needs the unit or HI/LO.

## Interface
- WIDTH, 16, operand width; HI and LO are each WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request from EX, qualified by op; sampled on the rising edge.
- op  in  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
- a  in  WIDTH  rs operand: multiplicand, dividend, or the MTHI/MTLO source.
- b  in  WIDTH  rt operand: multiplier or divisor.
- rdReq  in  1  an ID/EX instruction (MFHI/MFLO) wants to read HI/LO this cycle.
- busy  out  1  MUL or DIV iteration in progress.
- done  out  1  one-cycle pulse; HI/LO hold a new MULTU/DIVU result.
- divByZero  out  1  valid with done; the DIVU divisor was 0.
- stall  out  1  pipeline hold request.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States are IDLE, MUL, DIV and DONE. A 5-bit-or-wider iteration counter runs 0..WIDTH-1.
- **Reset:** state goes to IDLE. hi, lo, counter and internal accumulators clear to 0. busy, done, divByZero and stall are 0. Reset overrides everything, including an operation in flight; no partial result is written.
- **Acceptance:** start is accepted only in IDLE or DONE, so back-to-back operations are allowed. In MUL or DIV, start is ignored; the pipeline is held by stall and reissues the request.
- **MULTU:** latch a and b, clear the product accumulator, enter MUL, counter = 0.
  - Each MUL cycle: if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator (carry kept); then shift right by 1.
  - After iteration WIDTH-1, hi = product[2W-1:W] and lo = product[W-1:0]. Enter DONE.
- **DIVU, b != 0:** enter DIV. Each cycle performs one restoring step on a {remainder, quotient} shift register.
  - Shift left, trial-subtract the divisor from the remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
  - After WIDTH iterations, lo = quotient and hi = remainder. Enter DONE.
- **DIVU, b == 0:** go straight to DONE on the next edge. hi = a, lo = all ones, divByZero = 1 during the DONE cycle.
- **MTHI / MTLO:** on the accepting edge hi <= a (MTHI) or lo <= a (MTLO). State goes to IDLE; busy and done stay 0.
- **DONE:** lasts exactly one cycle with done = 1, then goes to IDLE unless a new start is accepted.
- **Unsigned only:** all arithmetic is unsigned. The multiply cannot overflow 2*WIDTH bits.
- **stall** = busy & (start | rdReq). This is combinational from the current state and inputs.
  - No stall in IDLE or DONE.
  - MFHI/MFLO in the DONE cycle reads the new result.

## Timing
- **MULTU / DIVU latency:** start sampled at edge E0.
  - busy = 1 for the WIDTH cycles following E0.
  - hi/lo update at edge E(WIDTH).
  - done = 1 in the cycle after E(WIDTH), i.e. WIDTH+1 edges from request to done.
- **DIVU by zero:** done in the cycle after E1.
- **MTHI / MTLO:** hi/lo visible in the cycle after E0; no busy.
- **hi/lo stability:** hi and lo are registered and change only on a completing edge, an MTHI/MTLO edge, or reset. They keep their old values throughout MUL and DIV.
- **Simultaneous events:**
  - start and rst together: rst wins.
  - start in DONE: DONE's done pulse still appears for that cycle, and the new operation's first iteration begins on the same edge that leaves DONE.

## Test plan
- **MULTU, WIDTH=16:** a=300, b=200. busy high 16 cycles, then done. hi=0x0000, lo=0xEA60, divByZero=0.
- **MULTU worst case:** a=0xFFFF, b=0xFFFF gives hi=0xFFFE, lo=0x0001. Issue DIVU a=100, b=7 in the DONE cycle. Second op completes 17 edges later with lo=14, hi=2.
- **DIVU by zero:** a=0x1234, b=0 gives done on the 2nd cycle after start, hi=0x1234, lo=0xFFFF, divByZero=1. busy is never high.
- **Stall:** during MULTU, assert rdReq at cycle 5, then start at cycle 9. stall = 1 exactly in those cycles. The start at cycle 9 is ignored (state stays MUL, result unchanged). With rdReq held in DONE, stall = 0.
- **Reset mid-op:** start MULTU 300×200, assert rst at busy cycle 7. Next cycle busy=0, done=0, hi=lo=0. No done pulse follows.
- **MTHI / MTLO:** MTHI a=0xBEEF, then MTLO a=0x1357. hi=0xBEEF, lo=0x1357 one cycle after each. busy and stall stay 0.
